// File: rtl/fifo_drain_pkg.sv
// Shared types for the FIFO drain framer: FSM encoding, burst counter width, counter sizing helper.
package fifo_drain_pkg;

  typedef enum logic [1:0] {DRN_IDLE, DRN_ACTIVE, DRN_CLOSING} drain_state_e;

  localparam int BURST_CNT_W = 16;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_drain_framer_if.sv
// Burst output stream (valid/ready with last); m_cksum exists only when FIFO_DRAIN_CKSUM_EN is defined.
interface fifo_drain_framer_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_last;
  logic                  m_ready;
`ifdef FIFO_DRAIN_CKSUM_EN
  logic [DATA_WIDTH-1:0] m_cksum;

  modport master (output m_data, output m_valid, output m_last, output m_cksum, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, input m_cksum, output m_ready);
`else
  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
`endif
endinterface

// File: rtl/fifo_drain_skid.sv
// Two-entry in-order word buffer; a write and a pop in the same cycle keep FIFO order.
// Zero-latency head; caller guarantees no overflow and pops only a valid head.
module fifo_drain_skid #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] wr_dat_i,
  input  logic                  pop_i,
  output logic                  head_vld_o,
  output logic [DATA_WIDTH-1:0] head_dat_o,
  output logic                  second_vld_o
);

  logic [DATA_WIDTH-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
  logic                  vld0_q, vld0_d, vld1_q, vld1_d;

  // Pop shifts first, so a same-cycle write lands behind any surviving entry.
  always_comb begin
    dat0_d = dat0_q;
    dat1_d = dat1_q;
    vld0_d = vld0_q;
    vld1_d = vld1_q;
    if (pop_i) begin
      dat0_d = dat1_q;
      vld0_d = vld1_q;
      vld1_d = 1'b0;
    end
    if (wr_i) begin
      if (vld0_d) begin
        dat1_d = wr_dat_i;
        vld1_d = 1'b1;
      end else begin
        dat0_d = wr_dat_i;
        vld0_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dat0_q <= '0;
      dat1_q <= '0;
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
    end else begin
      dat0_q <= dat0_d;
      dat1_q <= dat1_d;
      vld0_q <= vld0_d;
      vld1_q <= vld1_d;
    end
  end

  assign head_vld_o   = vld0_q;
  assign head_dat_o   = dat0_q;
  assign second_vld_o = vld1_q;

endmodule

// File: rtl/fifo_drain_framer.sv
// Pops the sync FIFO and frames words into bursts closed by length, starvation timeout or flush.
// Head held back until m_last is known; stalls on m_ready. FIFO_DRAIN_CKSUM_EN adds a per-burst XOR.
module fifo_drain_framer
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  fifo_dout,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic                   flush,
  fifo_drain_framer_if.master    m,
  output logic [BURST_CNT_W-1:0] burst_cnt,
  output logic                   busy
);

  localparam int BEAT_W = cnt_w(BURST_LEN);
  localparam int IDLE_W = cnt_w(TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);

  drain_state_e           state_q, state_d;
  logic                   inflight_q;
  logic                   close_req_q, close_req_d;
  logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic                  head_vld, second_vld;
  logic [DATA_WIDTH-1:0] head_dat;
  logic                  at_last_beat, xfer, last_xfer, starving, timeout_hit, remains, close_set;
  logic [1:0]            in_hand;

  fifo_drain_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk          (clk),
    .rst          (rst),
    .wr_i         (inflight_q),
    .wr_dat_i     (fifo_dout),
    .pop_i        (xfer),
    .head_vld_o   (head_vld),
    .head_dat_o   (head_dat),
    .second_vld_o (second_vld)
  );

  assign in_hand    = 2'(head_vld) + 2'(second_vld) + 2'(inflight_q);
  assign fifo_rd_en = !rst && !fifo_empty && (in_hand < 2'd2) && (state_q != DRN_CLOSING);

  // A lone head waits until we know whether it ends the burst.
  assign at_last_beat = (beat_cnt_q == LAST_BEAT);
  assign m.m_valid    = head_vld && (at_last_beat || second_vld || inflight_q || close_req_q);
  assign m.m_last     = m.m_valid && (at_last_beat || (close_req_q && !second_vld && !inflight_q));
  assign m.m_data     = head_dat;

  assign xfer        = m.m_valid && m.m_ready;
  assign last_xfer   = xfer && m.m_last;
  assign starving    = head_vld && !second_vld && !inflight_q && fifo_empty;
  assign timeout_hit = starving && (idle_cnt_q == IDLE_MAX - IDLE_W'(1));
  // A close needs at least one word left after this cycle, otherwise it would frame an empty burst.
  assign remains     = second_vld || inflight_q || (head_vld && !xfer);
  assign close_set   = !close_req_q && ((flush && remains) || (timeout_hit && !xfer));

  always_comb begin
    state_d     = state_q;
    close_req_d = (close_req_q && !last_xfer) || close_set;
    beat_cnt_d  = beat_cnt_q;
    burst_cnt_d = burst_cnt_q;
    idle_cnt_d  = '0;

    if (last_xfer) begin
      beat_cnt_d  = '0;
      burst_cnt_d = burst_cnt_q + BURST_CNT_W'(1);
    end else if (xfer) begin
      beat_cnt_d = beat_cnt_q + BEAT_W'(1);
    end

    if (starving) begin
      idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
    end

    unique case (state_q)
      DRN_IDLE: begin
        if (inflight_q) state_d = close_set ? DRN_CLOSING : DRN_ACTIVE;
      end
      DRN_ACTIVE: begin
        if (close_set) state_d = DRN_CLOSING;
        else if (last_xfer && !second_vld && !inflight_q) state_d = DRN_IDLE;
      end
      DRN_CLOSING: begin
        if (close_set) state_d = DRN_CLOSING;
        else if (last_xfer) state_d = (second_vld || inflight_q) ? DRN_ACTIVE : DRN_IDLE;
      end
      default: state_d = DRN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DRN_IDLE;
      inflight_q  <= 1'b0;
      close_req_q <= 1'b0;
      beat_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= fifo_rd_en;
      close_req_q <= close_req_d;
      beat_cnt_q  <= beat_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign burst_cnt = burst_cnt_q;
  assign busy      = (state_q != DRN_IDLE);

`ifdef FIFO_DRAIN_CKSUM_EN
  logic [DATA_WIDTH-1:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (last_xfer)  cksum_d = '0;
    else if (xfer)  cksum_d = cksum_q ^ head_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) cksum_q <= '0;
    else     cksum_q <= cksum_d;
  end

  assign m.m_cksum = cksum_q ^ head_dat;
`endif

endmodule

// File: tb/tb_fifo_drain_framer.sv
// Bench for fifo_drain_framer: FIFO model, beat scoreboard, table of stream cases plus flush/reset sequences.
module tb_fifo_drain_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] fifo_dout = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic        flush = 1'b0;
  logic [15:0] burst_cnt;
  logic        busy;

  fifo_drain_framer_if #(.DATA_WIDTH(16)) mif ();

  fifo_drain_framer #(.DATA_WIDTH(16), .BURST_LEN(4), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .m          (mif.master),
    .burst_cnt  (burst_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pre_rst;
    logic [15:0] base;
    int          n;
    logic [3:0]  pat;
    int          exp_bursts;
    int          exp_gap;
  } row_t;

  typedef struct packed {
    logic [15:0] dat;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] fq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          outstanding = 0;
  int          xfers = 0;
  int          gap = 0;
  int          last_gap = -1;
  int          exp_total = 0;
  logic        closing_win = 1'b0;
  logic        held_vld = 1'b0;
  logic [15:0] held_dat = '0;
  logic        held_last = 1'b0;
  logic [15:0] cks_acc = '0;
  logic [15:0] last_ck = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
  endtask

  task automatic reset_bench();
    fq.delete();
    sb.delete();
    outstanding = 0;
    held_vld    = 1'b0;
    cks_acc     = '0;
    fifo_empty  = 1'b1;
    fifo_dout   = '0;
  endtask

  task automatic push_word(input logic [15:0] w, input logic last);
    exp_t e;
    e.dat  = w;
    e.last = last;
    fq.push_back(w);
    sb.push_back(e);
    fifo_empty = 1'b0;
  endtask

  // One clock: observe at negedge, then update the FIFO model just after posedge.
  task automatic step();
    logic rd_s, xfer_s;
    exp_t e;
    @(negedge clk);
    if (rst) begin
      held_vld = 1'b0;
    end else begin
      if (held_vld) begin
        check("stall_valid", mif.m_valid, 1'b1);
        check("stall_data", mif.m_data, held_dat);
        check("stall_last", mif.m_last, held_last);
      end
      if (fifo_rd_en) check("rd_gate", outstanding < 2, 1'b1);
      if (closing_win) check("closing_rd", fifo_rd_en, 1'b0);
      if (mif.m_valid && mif.m_ready) begin
        last_gap = gap;
        gap = 0;
        xfers++;
        if (sb.size() == 0) begin
          flag_fail("extra_beat");
        end else begin
          e = sb.pop_front();
          check("beat_data", mif.m_data, e.dat);
          check("beat_last", mif.m_last, e.last);
        end
`ifdef FIFO_DRAIN_CKSUM_EN
        if (mif.m_last) begin
          check("cksum", mif.m_cksum, cks_acc ^ mif.m_data);
          last_ck = mif.m_cksum;
          cks_acc = '0;
        end else begin
          cks_acc = cks_acc ^ mif.m_data;
        end
`endif
      end else begin
        gap++;
      end
      held_vld  = mif.m_valid && !mif.m_ready;
      held_dat  = mif.m_data;
      held_last = mif.m_last;
    end
    rd_s   = !rst && fifo_rd_en;
    xfer_s = !rst && mif.m_valid && mif.m_ready;
    @(posedge clk);
    #1;
    if (rd_s) begin
      if (fq.size() == 0) flag_fail("fifo_underflow");
      else fifo_dout = fq.pop_front();
      outstanding++;
    end
    if (xfer_s) outstanding--;
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic drain(input logic [3:0] pat, input string name);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 400) begin
      mif.m_ready = pat[3 - (k % 4)];
      step();
      k++;
    end
    if (k >= 400) flag_fail(name);
    mif.m_ready = 1'b1;
  endtask

  task automatic run_row(input row_t r);
    if (r.pre_rst) begin
      rst = 1'b1;
      reset_bench();
      exp_total = 0;
    end
    for (int i = 0; i < r.n; i++)
      push_word(r.base + 16'(i), (i % 4 == 3) || (i == r.n - 1));
    if (r.pre_rst) begin
      step();
      step();
      rst = 1'b0;
    end
    last_gap = -1;
    gap = 0;
    drain(r.pat, "row_timeout");
    exp_total += r.exp_bursts;
    check("burst_cnt", 32'(burst_cnt), 32'(exp_total[15:0]));
    check("busy_idle", busy, 1'b0);
    if (r.exp_gap >= 0) check("starve_gap", 32'(last_gap), 32'(r.exp_gap));
  endtask

  row_t rows[4];
  row_t fresh;

  initial begin
    int k, x0;
    rows[0] = '{1'b1, 16'h0001,  8, 4'b1111, 2, -1};
    rows[1] = '{1'b1, 16'h00A0,  2, 4'b1111, 1,  8};
    rows[2] = '{1'b0, 16'h0100, 12, 4'b1001, 3, -1};
    rows[3] = '{1'b0, 16'h0200,  5, 4'b1111, 2, -1};
    fresh   = '{1'b0, 16'h0400,  4, 4'b1111, 1, -1};
    mif.m_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    step();
    step();
    check("rst_valid", mif.m_valid, 1'b0);
    check("rst_last", mif.m_last, 1'b0);
    check("rst_data", mif.m_data, 16'h0000);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_burst_cnt", 32'(burst_cnt), 32'd0);

    for (int r = 0; r < 4; r++) run_row(rows[r]);

    // Flush with two words buffered: no reads until the flushed burst ends on its 3rd beat
    mif.m_ready = 1'b0;
    push_word(16'h00C0, 1'b0);
    push_word(16'h00C1, 1'b0);
    push_word(16'h00C2, 1'b1);
    repeat (6) step();
    mif.m_ready = 1'b1;
    step();
    mif.m_ready = 1'b0;
    repeat (5) step();
    check("pre_flush_beats", 32'(sb.size()), 32'd2);
    flush = 1'b1;
    closing_win = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) push_word(16'h00C3 + 16'(i), i == 3);
    mif.m_ready = 1'b1;
    x0 = xfers;
    k = 0;
    while (xfers < x0 + 2 && k < 50) begin
      step();
      k++;
    end
    if (k >= 50) flag_fail("flush_close");
    closing_win = 1'b0;
    check("flush_burst_cnt", 32'(burst_cnt), 32'(exp_total + 1));
    drain(4'b1111, "flush_resume");
    exp_total += 2;
    check("resume_burst_cnt", 32'(burst_cnt), 32'(exp_total));
    check("resume_sb_empty", 32'(sb.size()), 32'd0);

    // Reset two beats into a burst, then a fresh burst
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.dat  = 16'h0300 + 16'(i);
      e.last = 1'b0;
      fq.push_back(e.dat);
      if (i < 2) sb.push_back(e);
    end
    fifo_empty = 1'b0;
    x0 = xfers;
    k = 0;
    while (xfers < x0 + 2 && k < 50) begin
      step();
      k++;
    end
    if (k >= 50) flag_fail("pre_rst_beats");
    rst = 1'b1;
    step();
    step();
    check("midrst_valid", mif.m_valid, 1'b0);
    check("midrst_last", mif.m_last, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_burst_cnt", 32'(burst_cnt), 32'd0);
    check("midrst_data", mif.m_data, 16'h0000);
    reset_bench();
    exp_total = 0;
    rst = 1'b0;
    step();
    run_row(fresh);

`ifdef FIFO_DRAIN_CKSUM_EN
    push_word(16'h1111, 1'b0);
    push_word(16'h2222, 1'b0);
    push_word(16'h4444, 1'b0);
    push_word(16'h8888, 1'b1);
    drain(4'b1111, "cksum_drain");
    check("cksum_ffff", last_ck, 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
